// File: rtl/alu_cmd_dispatch.sv
// alu_cmd_dispatch: command front end for the 16-bit ALU.
// Queues {A, B, alu_fun} commands in a small FIFO and issues at most one per cycle.
// Each issue drives registered operands and a one-hot unit enable.
// res_valid marks the cycle in which the selected unit's registered result is valid.
// Optional feature: define ALU_DISPATCH_STATS_EN to add the issue_cnt/drop_cnt counters.
module alu_cmd_dispatch #(
   parameter int unsigned Data_In_Width = 16,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                         CLK_in,
   input  logic                         RST_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [Data_In_Width-1:0]     A_in,
   input  logic [Data_In_Width-1:0]     B_in,
   input  logic [3:0]                   alu_fun,
   input  logic                         stall,
   output logic [Data_In_Width-1:0]     A_out,
   output logic [Data_In_Width-1:0]     B_out,
   output logic [3:0]                   alu_fun_out,
   output logic                         arith_En,
   output logic                         logic_En,
   output logic                         cmp_En,
   output logic                         shift_En,
   output logic                         res_valid,
   output logic [1:0]                   res_unit,
`ifdef ALU_DISPATCH_STATS_EN
   output logic [15:0]                  issue_cnt,
   output logic [15:0]                  drop_cnt,
`endif
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned EntryW = 2 * Data_In_Width + 4;
   localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

   logic [EntryW-1:0] mem [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic              full, empty, push, pop;
   logic [EntryW-1:0] head;

   assign full       = (count_q == FullCnt);
   assign empty      = (count_q == '0);
   assign in_ready   = !full;
   assign push       = in_valid & in_ready;
   assign pop        = !empty & !stall;
   assign head       = mem[rd_ptr_q];
   assign fifo_count = count_q;

   // Command storage; no reset needed, validity is tracked by count_q.
   always_ff @(posedge CLK_in) begin
      if (push) begin
         mem[wr_ptr_q] <= {A_in, B_in, alu_fun};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge CLK_in or negedge RST_in) begin
      if (!RST_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Issue stage: registered operands plus a one-hot enable decoded from the head entry.
   always_ff @(posedge CLK_in or negedge RST_in) begin
      if (!RST_in) begin
         A_out       <= '0;
         B_out       <= '0;
         alu_fun_out <= '0;
         arith_En    <= 1'b0;
         logic_En    <= 1'b0;
         cmp_En      <= 1'b0;
         shift_En    <= 1'b0;
      end else begin
         arith_En <= 1'b0;
         logic_En <= 1'b0;
         cmp_En   <= 1'b0;
         shift_En <= 1'b0;
         if (pop) begin
            A_out       <= head[EntryW-1 -: Data_In_Width];
            B_out       <= head[Data_In_Width+3 : 4];
            alu_fun_out <= head[3:0];
            unique case (head[3:2])
               2'b00: arith_En <= 1'b1;
               2'b01: logic_En <= 1'b1;
               2'b10: cmp_En   <= 1'b1;
               2'b11: shift_En <= 1'b1;
            endcase
         end
      end
   end

   // Result tracking: mirrors the units' single registered stage, unaffected by stall.
   always_ff @(posedge CLK_in or negedge RST_in) begin
      if (!RST_in) begin
         res_valid <= 1'b0;
         res_unit  <= 2'b00;
      end else begin
         res_valid <= arith_En | logic_En | cmp_En | shift_En;
         if (arith_En | logic_En | cmp_En | shift_En) begin
            res_unit <= alu_fun_out[3:2];
         end
      end
   end

`ifdef ALU_DISPATCH_STATS_EN
   // Issue counter wraps; drop counter saturates on refused pushes.
   always_ff @(posedge CLK_in or negedge RST_in) begin
      if (!RST_in) begin
         issue_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (pop) issue_cnt <= issue_cnt + 16'd1;
         if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_dispatch.sv
// Directed self-checking bench for alu_cmd_dispatch.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_alu_cmd_dispatch;

   logic        CLK_in;
   logic        RST_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A_in, B_in;
   logic [3:0]  alu_fun;
   logic        stall;
   logic [15:0] A_out, B_out;
   logic [3:0]  alu_fun_out;
   logic        arith_En, logic_En, cmp_En, shift_En;
   logic        res_valid;
   logic [1:0]  res_unit;
   logic [2:0]  fifo_count;
`ifdef ALU_DISPATCH_STATS_EN
   logic [15:0] issue_cnt, drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   alu_cmd_dispatch #(.Data_In_Width(16), .FIFO_DEPTH(4)) dut (
      .CLK_in      (CLK_in),
      .RST_in      (RST_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A_in        (A_in),
      .B_in        (B_in),
      .alu_fun     (alu_fun),
      .stall       (stall),
      .A_out       (A_out),
      .B_out       (B_out),
      .alu_fun_out (alu_fun_out),
      .arith_En    (arith_En),
      .logic_En    (logic_En),
      .cmp_En      (cmp_En),
      .shift_En    (shift_En),
      .res_valid   (res_valid),
      .res_unit    (res_unit),
`ifdef ALU_DISPATCH_STATS_EN
      .issue_cnt   (issue_cnt),
      .drop_cnt    (drop_cnt),
`endif
      .fifo_count  (fifo_count)
   );

   initial CLK_in = 1'b0;
   always #5 CLK_in = ~CLK_in;

   task automatic tick();
      @(posedge CLK_in);
      #1;
   endtask

   task automatic test_reset();
      RST_in = 1'b0; in_valid = 1'b0; stall = 1'b0;
      A_in = '0; B_in = '0; alu_fun = '0;
      #1;
      checks++;
      if ({A_out, B_out, alu_fun_out, arith_En, logic_En, cmp_En, shift_En, res_valid, res_unit,
           fifo_count} !== '0) begin
         errors++; $display("FAIL reset_outputs: got A=%h B=%h f=%h cnt=%0d, want all zero",
                            A_out, B_out, alu_fun_out, fifo_count);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      tick(); tick();
      #2 RST_in = 1'b1;
      tick();
   endtask

   task automatic test_single();
      in_valid = 1'b1; A_in = 16'sd5; B_in = -16'sd3; alu_fun = 4'b1011;
      tick();  // edge 0: push
      in_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'd1 || cmp_En !== 1'b0) begin
         errors++; $display("FAIL single_push: got cnt=%0d cmp=%b want cnt=1 cmp=0",
                            fifo_count, cmp_En);
      end
      tick();  // edge 1: issue
      checks++;
      if ({arith_En, logic_En, cmp_En, shift_En} !== 4'b0010 || A_out !== 16'd5 ||
          B_out !== 16'hFFFD || alu_fun_out !== 4'b1011 || res_valid !== 1'b0) begin
         errors++; $display("FAIL single_issue: got en=%b A=%h B=%h f=%b rv=%b want 0010 0005 FFFD 1011 0",
                            {arith_En, logic_En, cmp_En, shift_En}, A_out, B_out, alu_fun_out,
                            res_valid);
      end
      tick();  // edge 2: result
      checks++;
      if (res_valid !== 1'b1 || res_unit !== 2'b10 || cmp_En !== 1'b0) begin
         errors++; $display("FAIL single_result: got rv=%b unit=%b cmp=%b want 1 10 0",
                            res_valid, res_unit, cmp_En);
      end
   endtask

   task automatic test_reset_midstream();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; A_in = 16'(100 + i); B_in = 16'(200 + i); alu_fun = 4'b0001;
         tick();
      end
      in_valid = 1'b0; stall = 1'b0;
      tick();  // first queued command issues
      checks++;
      if (arith_En !== 1'b1 || fifo_count !== 3'd2 || A_out !== 16'd100) begin
         errors++; $display("FAIL midstream_pre: got en=%b cnt=%0d A=%h want 1 2 0064",
                            arith_En, fifo_count, A_out);
      end
      #2 RST_in = 1'b0;
      #1;
      checks++;
      if ({A_out, B_out, alu_fun_out, arith_En, logic_En, cmp_En, shift_En, res_valid, res_unit,
           fifo_count} !== '0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL midstream_async_reset: got A=%h B=%h en=%b cnt=%0d rdy=%b want zeros rdy=1",
                            A_out, B_out, {arith_En, logic_En, cmp_En, shift_En}, fifo_count,
                            in_ready);
      end
      #2 RST_in = 1'b1;
      tick(); tick();
      checks++;
      if (fifo_count !== 3'd0 || in_ready !== 1'b1 || res_valid !== 1'b0 ||
          {arith_En, logic_En, cmp_En, shift_En} !== 4'b0000) begin
         errors++; $display("FAIL post_reset: got cnt=%0d rdy=%b rv=%b en=%b want 0 1 0 0000",
                            fifo_count, in_ready, res_valid, {arith_En, logic_En, cmp_En, shift_En});
      end
   endtask

   task automatic test_fill_drain();
      logic [3:0] funs [4];
      funs[0] = 4'b0001; funs[1] = 4'b0110; funs[2] = 4'b1000; funs[3] = 4'b1111;
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; A_in = 16'(10 + i); B_in = 16'(20 + i); alu_fun = funs[i];
         tick();
      end
      checks++;
      if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
         errors++; $display("FAIL fill_full: got cnt=%0d rdy=%b want 4 0", fifo_count, in_ready);
      end
      A_in = 16'd99; alu_fun = 4'b0000;
      tick();  // refused 5th push
      checks++;
      if (fifo_count !== 3'd4 || {arith_En, logic_En, cmp_En, shift_En} !== 4'b0000) begin
         errors++; $display("FAIL fill_refuse: got cnt=%0d en=%b want 4 0000",
                            fifo_count, {arith_En, logic_En, cmp_En, shift_En});
      end
      in_valid = 1'b0; stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (A_out !== 16'(10 + i) || B_out !== 16'(20 + i) || alu_fun_out !== funs[i] ||
             {shift_En, cmp_En, logic_En, arith_En} !== (4'b0001 << funs[i][3:2])) begin
            errors++; $display("FAIL drain_%0d: got A=%h B=%h f=%b en=%b", i, A_out, B_out,
                               alu_fun_out, {shift_En, cmp_En, logic_En, arith_En});
         end
      end
      tick();
      checks++;
      if ({arith_En, logic_En, cmp_En, shift_En} !== 4'b0000 || fifo_count !== 3'd0 ||
          res_valid !== 1'b1 || res_unit !== 2'b11) begin
         errors++; $display("FAIL drain_idle: got en=%b cnt=%0d rv=%b unit=%b want 0000 0 1 11",
                            {arith_En, logic_En, cmp_En, shift_En}, fifo_count, res_valid, res_unit);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  fq [10];
      logic [15:0] aq [10];
      int bad;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         fq[k] = 4'((k * 7 + 3) % 16);
         aq[k] = 16'(16'h1000 + k);
      end
      stall = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         in_valid = (k < 10);
         if (k < 10) begin
            A_in = aq[k]; B_in = ~aq[k]; alu_fun = fq[k];
         end
         tick();
         if (k >= 1) begin
            if (A_out !== aq[k-1] || B_out !== ~aq[k-1] || alu_fun_out !== fq[k-1] ||
                {shift_En, cmp_En, logic_En, arith_En} !== (4'b0001 << fq[k-1][3:2]) ||
                fifo_count !== ((k < 10) ? 3'd1 : 3'd0)) begin
               bad++; $display("FAIL stream_issue_%0d: got A=%h f=%b en=%b cnt=%0d want A=%h f=%b",
                               k - 1, A_out, alu_fun_out, {shift_En, cmp_En, logic_En, arith_En},
                               fifo_count, aq[k-1], fq[k-1]);
            end
         end else if (fifo_count !== 3'd1) begin
            bad++; $display("FAIL stream_first_push: got cnt=%0d want 1", fifo_count);
         end
         if (k >= 2 && (res_valid !== 1'b1 || res_unit !== fq[k-2][3:2])) begin
            bad++; $display("FAIL stream_result_%0d: got rv=%b unit=%b want 1 %b", k - 2, res_valid,
                            res_unit, fq[k-2][3:2]);
         end
      end
      in_valid = 1'b0;
      checks++;
      if (bad != 0) errors++;
      tick(); tick();
   endtask

   task automatic test_stall_after_issue();
      stall = 1'b0;
      in_valid = 1'b1; A_in = 16'h0A0A; B_in = 16'h0001; alu_fun = 4'b0010;
      tick();  // push arith
      A_in = 16'h0B0B; B_in = 16'h0002; alu_fun = 4'b0101;
      tick();  // push logic, issue arith
      checks++;
      if (arith_En !== 1'b1 || A_out !== 16'h0A0A) begin
         errors++; $display("FAIL stall_arith_issue: got en=%b A=%h want 1 0A0A", arith_En, A_out);
      end
      in_valid = 1'b0; stall = 1'b1;
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_unit !== 2'b00 ||
          {arith_En, logic_En, cmp_En, shift_En} !== 4'b0000 || fifo_count !== 3'd1 ||
          A_out !== 16'h0A0A) begin
         errors++; $display("FAIL stall_result: got rv=%b unit=%b en=%b cnt=%0d A=%h want 1 00 0000 1 0A0A",
                            res_valid, res_unit, {arith_En, logic_En, cmp_En, shift_En}, fifo_count,
                            A_out);
      end
      tick();
      checks++;
      if (res_valid !== 1'b0 || {arith_En, logic_En, cmp_En, shift_En} !== 4'b0000) begin
         errors++; $display("FAIL stall_hold: got rv=%b en=%b want 0 0000", res_valid,
                            {arith_En, logic_En, cmp_En, shift_En});
      end
      stall = 1'b0;
      tick();
      checks++;
      if (logic_En !== 1'b1 || A_out !== 16'h0B0B || fifo_count !== 3'd0) begin
         errors++; $display("FAIL stall_release: got logic=%b A=%h cnt=%0d want 1 0B0B 0",
                            logic_En, A_out, fifo_count);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_unit !== 2'b01) begin
         errors++; $display("FAIL stall_release_result: got rv=%b unit=%b want 1 01", res_valid,
                            res_unit);
      end
   endtask

`ifdef ALU_DISPATCH_STATS_EN
   task automatic test_stats();
      #2 RST_in = 1'b0;
      #2 RST_in = 1'b1;
      tick();
      stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; A_in = 16'(i); B_in = 16'(i); alu_fun = 4'(i);
         tick();  // pushes 4..5 are refused
      end
      in_valid = 1'b0; stall = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; A_in = 16'(i); B_in = 16'(i); alu_fun = 4'(i);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      checks++;
      if (issue_cnt !== 16'd6 || drop_cnt !== 16'd2) begin
         errors++; $display("FAIL stats: got issue=%0d drop=%0d want 6 2", issue_cnt, drop_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_reset_midstream();
      test_fill_drain();
      test_back_to_back();
      test_stall_after_issue();
`ifdef ALU_DISPATCH_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
